// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit-side consumer of the UART TX FIFO. Pops one byte at a time with an
// active-low read strobe and waits out the FIFO read latency. It then latches
// the byte together with the frame configuration and shifts out one
// asynchronous frame: start bit, 7 or 8 data bits LSB first, optional
// parity, and 1 or 2 stop bits. Every bit lasts 16 baud_tick pulses.
//
// State table:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | line idle high, waiting for the FIFO to become non-empty
//   FETCH  | one-clock pop strobe (fifo_read_n = 0)
//   WAIT   | waiting out the FIFO read latency; byte + config latched at end
//   ARM    | byte ready, waiting for a baud_tick to align the start bit
//   START  | start bit (txd = 0) for 16 ticks
//   DATA   | data bits, LSB first, 16 ticks each
//   PARITY | optional parity bit
//   STOP   | stop bit(s), txd = 1, 16 ticks each
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   baud_tick    one-clock pulse at 16x the baud rate
//   bit8         1 = 8 data bits, 0 = 7 data bits
//   parity_en    1 = append a parity bit
//   odd_n_even   1 = odd parity, 0 = even parity
//   fifo_empty   TX FIFO empty flag
//   fifo_data    TX FIFO read data
//   fifo_read_n  active-low FIFO pop strobe, one clock per byte
//   txd          serial data out, idles high
//   tx_busy      high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter bit SYNC_RESET   = 1'b0,
    parameter int READ_LATENCY = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_n,
    output logic       txd,
    output logic       tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // The WAIT down-counter is loaded in FETCH and terminates at zero, so
    // WAIT spans READ_LATENCY clocks and the latch edge is the one that ends
    // the clock in which the FIFO presents valid data.
    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    // SYNC_RESET is carried only so the core can share one parameter set;
    // this block's flops always use the asynchronous reset.
    if (SYNC_RESET != 1'b0) begin : g_sync_reset_passthru
    end

    state_t     state;
    state_t     state_next;

    logic [1:0] wait_cnt;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic [7:0] shift_reg;
    logic       parity_acc;

    logic       cfg_bit8;
    logic       cfg_parity_en;
    logic       cfg_odd;

    logic       tick_wrap;
    logic       last_data_bit;
    logic       last_stop_bit;
    logic       wait_done;
    logic [2:0] last_bit_idx;

    assign tick_wrap     = baud_tick && (tick_cnt == 4'd15);
    assign last_bit_idx  = cfg_bit8 ? 3'd7 : 3'd6;
    assign last_data_bit = (bit_cnt == last_bit_idx);
    assign last_stop_bit = (stop_cnt == STOP_LAST);
    assign wait_done     = (wait_cnt == 2'd0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs. Outputs decode directly from registered state
    // so that an asynchronous reset forces the idle line level at once.
    always_comb begin
        state_next  = state;
        fifo_read_n = 1'b1;
        txd         = 1'b1;
        tx_busy     = 1'b1;

        case (state)
            S_IDLE: begin
                tx_busy = 1'b0;
                if (!fifo_empty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_read_n = 1'b0;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (baud_tick) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (tick_wrap) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                txd = shift_reg[0];
                if (tick_wrap && last_data_bit) begin
                    state_next = cfg_parity_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                txd = parity_acc ^ cfg_odd;
                if (tick_wrap) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_wrap && last_stop_bit) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Read-latency down-counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 2'd0;
        end else if (state == S_FETCH) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == S_WAIT && !wait_done) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // Byte and frame configuration capture. Config is frozen here so that
    // input changes during the frame cannot alter its shape.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg     <= 8'h00;
            parity_acc    <= 1'b0;
            cfg_bit8      <= 1'b0;
            cfg_parity_en <= 1'b0;
            cfg_odd       <= 1'b0;
        end else if (state == S_WAIT && wait_done) begin
            shift_reg     <= fifo_data;
            parity_acc    <= 1'b0;
            cfg_bit8      <= bit8;
            cfg_parity_en <= parity_en;
            cfg_odd       <= odd_n_even;
        end else if (state == S_DATA && tick_wrap) begin
            // Parity folds in only the bits actually sent, so a 7-bit frame
            // never includes fifo_data[7].
            shift_reg  <= {1'b0, shift_reg[7:1]};
            parity_acc <= parity_acc ^ shift_reg[0];
        end
    end

    // Tick counter: advances only on baud_tick while a frame is on the line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= 4'd0;
        end else if (state == S_ARM) begin
            if (baud_tick) begin
                tick_cnt <= 4'd0;
            end
        end else if (state == S_START || state == S_DATA ||
                     state == S_PARITY || state == S_STOP) begin
            if (baud_tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
        end
    end

    // Data-bit and stop-bit counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
        end else if (state == S_ARM && baud_tick) begin
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
        end else if (state == S_DATA && tick_wrap) begin
            bit_cnt <= bit_cnt + 3'd1;
        end else if (state == S_STOP && tick_wrap) begin
            stop_cnt <= stop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int READ_LATENCY = 2;
    localparam int STOP_BITS    = 1;
    localparam int TICK_GAP     = 4;
    localparam int WAIT_LIMIT   = 8000;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       baud_tick  = 1'b0;
    logic       bit8       = 1'b1;
    logic       parity_en  = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_read_n;
    logic       txd;
    logic       tx_busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    uart_tx_serializer #(
        .SYNC_RESET  (1'b0),
        .READ_LATENCY(READ_LATENCY),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read_n(fifo_read_n),
        .txd        (txd),
        .tx_busy    (tx_busy)
    );

    always #5 clock = ~clock;

    // Baud tick: one-clock pulse every TICK_GAP clocks
    initial begin
        forever begin
            repeat (TICK_GAP - 1) @(posedge clock);
            #1 baud_tick = 1'b1;
            @(posedge clock);
            #1 baud_tick = 1'b0;
        end
    end

    // FIFO model: data is valid only during the READ_LATENCY-th clock after
    // the pop, and shows the inverted byte otherwise so a mistimed latch is seen.
    logic [7:0] byte_mem [0:15];
    int         wr_idx    = 0;
    int         rd_idx    = 0;
    logic [7:0] pop_hold  = 8'h00;
    int         pop_age   = -1;
    int         rd_pulses = 0;
    int         rd_run    = 0;
    int         bad_width = 0;
    int         bad_reads = 0;

    assign fifo_empty = (wr_idx == rd_idx);

    always @(negedge clock) begin
        if (pop_age >= 0) begin
            pop_age = pop_age + 1;
            if (pop_age == READ_LATENCY) begin
                fifo_data = pop_hold;
            end else if (pop_age == READ_LATENCY + 1) begin
                fifo_data = ~pop_hold;
                pop_age   = -1;
            end
        end
        if (!fifo_read_n) begin
            if (rd_run == 0) rd_pulses = rd_pulses + 1;
            rd_run = rd_run + 1;
            if (wr_idx == rd_idx) begin
                bad_reads = bad_reads + 1;
            end else begin
                pop_hold  = byte_mem[rd_idx % 16];
                rd_idx    = rd_idx + 1;
                fifo_data = ~pop_hold;
                pop_age   = 0;
            end
        end else begin
            if (rd_run > 1) bad_width = bad_width + 1;
            rd_run = 0;
        end
    end

    // Line monitor: samples each bit at its 8th tick and records frames
    logic        in_frame  = 1'b0;
    int          mon_ticks = 0;
    logic [15:0] cur_bits  = 16'h0000;
    logic [15:0] obs_bits  [0:15];
    int          obs_ticks [0:15];
    logic        obs_gap   [0:15];
    int          obs_n     = 0;
    int          obs_rd    = 0;

    always @(negedge clock) begin
        if (reset) begin
            in_frame  = 1'b0;
            mon_ticks = 0;
        end else begin
            if (in_frame && !tx_busy) begin
                obs_bits[obs_n % 16]  = cur_bits;
                obs_ticks[obs_n % 16] = mon_ticks;
                obs_gap[obs_n % 16]   = txd;
                obs_n    = obs_n + 1;
                in_frame = 1'b0;
            end else if (!in_frame && tx_busy && !txd) begin
                in_frame  = 1'b1;
                mon_ticks = 0;
                cur_bits  = 16'h0000;
            end
            if (in_frame && baud_tick) begin
                if (((mon_ticks + 1) % 16) == 8 && ((mon_ticks + 1) / 16) < 16) begin
                    cur_bits[(mon_ticks + 1) / 16] = txd;
                end
                mon_ticks = mon_ticks + 1;
            end
        end
    end

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        string       tag;
    } frame_t;

    frame_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic b8, input logic pe,
                             input logic odd, input bit want_frame, input string tag);
        frame_t f;
        int     idx;
        logic   par;
        f.bits = 16'h0000;
        f.tag  = tag;
        idx    = 1;
        par    = odd;
        for (int i = 0; i < (b8 ? 8 : 7); i++) begin
            f.bits[idx] = b[i];
            par         = par ^ b[i];
            idx++;
        end
        if (pe) begin
            f.bits[idx] = par;
            idx++;
        end
        for (int s = 0; s < STOP_BITS; s++) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.nbits    = idx;
        bit8       = b8;
        parity_en  = pe;
        odd_n_even = odd;
        byte_mem[wr_idx % 16] = b;
        wr_idx = wr_idx + 1;
        if (want_frame) exp_q.push_back(f);
    endtask

    task automatic wait_in_frame(input string tag);
        int c;
        c = 0;
        while (!in_frame && c < WAIT_LIMIT) begin
            @(negedge clock);
            c++;
        end
        check({tag, "_start_seen"}, 32'(in_frame), 32'd1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int c;
        c = 0;
        while (obs_n < target && c < WAIT_LIMIT) begin
            @(negedge clock);
            c++;
        end
        check({tag, "_frames_done"}, 32'(obs_n), 32'(target));
    endtask

    task automatic check_frame();
        frame_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, "_bits"},    32'(obs_bits[obs_rd % 16]),  32'(e.bits));
        check({e.tag, "_ticks"},   32'(obs_ticks[obs_rd % 16]), 32'(16 * e.nbits));
        check({e.tag, "_gap_txd"}, 32'(obs_gap[obs_rd % 16]),   32'd1);
        obs_rd++;
    endtask

    // Sends one byte, flips the config inputs once the frame is on the line,
    // and checks the recorded frame against the scoreboard.
    task automatic single_frame(input logic [7:0] b, input logic b8, input logic pe,
                                input logic odd, input int pulses, input string tag);
        @(negedge clock);
        push_byte(b, b8, pe, odd, 1'b1, tag);
        wait_in_frame(tag);
        bit8       = ~b8;
        parity_en  = ~pe;
        odd_n_even = ~odd;
        wait_frames(obs_n + 1, tag);
        check_frame();
        check({tag, "_read_pulses"}, 32'(rd_pulses), 32'(pulses));
    endtask

    initial begin
        int c;

        // Reset held, then released with an empty FIFO
        repeat (5) begin
            @(negedge clock);
            check("rst_txd",    32'(txd),         32'd1);
            check("rst_readn",  32'(fifo_read_n), 32'd1);
            check("rst_busy",   32'(tx_busy),     32'd0);
        end
        reset = 1'b0;
        repeat (100) begin
            @(negedge clock);
            check("idle_txd",   32'(txd),         32'd1);
            check("idle_readn", 32'(fifo_read_n), 32'd1);
            check("idle_busy",  32'(tx_busy),     32'd0);
        end
        check("idle_no_read", 32'(rd_pulses), 32'd0);

        single_frame(8'h55, 1'b1, 1'b0, 1'b0, 1, "b55_8n1");
        single_frame(8'hA5, 1'b1, 1'b1, 1'b0, 2, "bA5_even");
        single_frame(8'hA5, 1'b1, 1'b1, 1'b1, 3, "bA5_odd");
        single_frame(8'hFF, 1'b0, 1'b0, 1'b0, 4, "bFF_7bit");

        // Back-to-back bytes with a stable configuration
        @(negedge clock);
        push_byte(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, "b01_first");
        push_byte(8'h80, 1'b1, 1'b0, 1'b0, 1'b1, "b80_second");
        wait_frames(obs_n + 2, "b2b");
        check_frame();
        check_frame();
        check("b2b_read_pulses", 32'(rd_pulses), 32'd6);

        // Reset in the middle of the data bits of 0x00
        @(negedge clock);
        push_byte(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "b00_abort");
        c = 0;
        while (!(in_frame && mon_ticks >= 52) && c < WAIT_LIMIT) begin
            @(negedge clock);
            c++;
        end
        check("abort_in_data", 32'(in_frame && mon_ticks >= 52), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_txd",   32'(txd),         32'd1);
        check("abort_busy",  32'(tx_busy),     32'd0);
        check("abort_readn", 32'(fifo_read_n), 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (100) begin
            @(negedge clock);
            check("post_txd",   32'(txd),         32'd1);
            check("post_busy",  32'(tx_busy),     32'd0);
            check("post_readn", 32'(fifo_read_n), 32'd1);
        end
        check("post_read_pulses", 32'(rd_pulses), 32'd7);
        check("post_frames",      32'(obs_n),     32'd6);
        check("read_width",       32'(bad_width), 32'd0);
        check("read_when_empty",  32'(bad_reads), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
